// File: rtl/ctrl_decode_pipe.sv
// Elastic RV32I control decoder: combinational decode into a DEPTH-stage valid/ready pipeline.
// Define CTRL_MDU_EN to accept the M-extension encoding (opcode 0110011, funct7 0000001).
module ctrl_decode_pipe #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned TAG_W     = 32,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_regwrite,
    output logic                 out_alusrc,
    output logic                 out_memwrite,
    output logic                 out_branch,
    output logic                 out_jump,
    output logic                 out_pcresultsrc,
    output logic [2:0]           out_immsrc,
    output logic [2:0]           out_resultsrc,
    output logic [1:0]           out_aluop,
    output logic                 out_mdu,
    output logic                 out_illegal,
    output logic [TAG_W-1:0]     out_tag,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam int unsigned LAST = DEPTH - 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef CTRL_MDU_EN
    localparam logic [6:0] F7_MDU  = 7'b0000001;
`endif

    typedef struct packed {
        logic       regwrite;
        logic [2:0] immsrc;
        logic       alusrc;
        logic       memwrite;
        logic [2:0] resultsrc;
        logic       branch;
        logic [1:0] aluop;
        logic       jump;
        logic       pcresultsrc;
    } ctrl_t;

    typedef struct packed {
        ctrl_t            ctrl;
        logic             mdu;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    ctrl_t      dec_ctrl;
    logic       dec_legal;
    logic       dec_mdu;
    stage_t     dec_entry;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Opcode decode plus legality; illegal encodings collapse to an all-zero bundle.
    always_comb begin
        dec_ctrl  = '0;
        dec_legal = 1'b1;
        dec_mdu   = 1'b0;
        case (opcode)
            OP_LOAD:   dec_ctrl = ctrl_t'(14'b1_000_1_0_001_0_00_0_0);
            OP_STORE:  dec_ctrl = ctrl_t'(14'b0_001_1_1_000_0_00_0_0);
            OP_RTYPE: begin
                dec_ctrl = ctrl_t'(14'b1_000_0_0_000_0_10_0_0);
                if (funct7 == F7_ALT) begin
                    dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end
`ifdef CTRL_MDU_EN
                else if (funct7 == F7_MDU) begin
                    dec_mdu = 1'b1;
                end
`endif
                else if (funct7 != F7_ZERO) begin
                    dec_legal = 1'b0;
                end
            end
            OP_BRANCH: begin
                dec_ctrl  = ctrl_t'(14'b0_010_0_0_000_1_01_0_0);
                dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_ITYPE: begin
                dec_ctrl = ctrl_t'(14'b1_000_1_0_000_0_10_0_0);
                if (funct3 == 3'b001) begin
                    dec_legal = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                end
            end
            OP_JAL:    dec_ctrl = ctrl_t'(14'b1_011_0_0_010_0_00_1_0);
            OP_JALR: begin
                dec_ctrl  = ctrl_t'(14'b1_000_1_0_010_0_00_1_1);
                dec_legal = (funct3 == 3'b000);
            end
            OP_AUIPC:  dec_ctrl = ctrl_t'(14'b1_100_0_0_011_0_00_0_0);
            OP_LUI:    dec_ctrl = ctrl_t'(14'b1_100_0_0_100_0_00_0_0);
            default:   dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_ctrl = '0;
            dec_mdu  = 1'b0;
        end
    end

    assign dec_entry = '{ctrl: dec_ctrl, mdu: dec_mdu, illegal: !dec_legal, tag: in_tag};

    logic [DEPTH-1:0]     v_q;
    logic [DEPTH-1:0]     v_d;
    logic [DEPTH-1:0]     rdy;
    stage_t               data_q [DEPTH];
    stage_t               data_d [DEPTH];
    logic [ILL_CNT_W-1:0] ill_q;
    logic [ILL_CNT_W-1:0] ill_d;
    logic                 accept;

    // A stage is stalled only when it and every stage after it are full and the consumer is stalled.
    always_comb begin : ready_calc
        logic stall;
        stall = !out_ready;
        rdy   = '0;
        for (int k = int'(LAST); k >= 0; k--) begin
            stall  = stall & v_q[k];
            rdy[k] = !stall;
        end
    end

    assign in_ready = rdy[0] & !flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        ill_d  = ill_q;
        if (flush) begin
            v_d = '0;
        end else begin
            for (int k = int'(LAST); k >= 1; k--) begin
                if (rdy[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
            if (rdy[0]) begin
                v_d[0] = accept;
                if (accept) begin
                    data_d[0] = dec_entry;
                end
            end
        end
        if (accept && !dec_legal && (ill_q != '1)) begin
            ill_d = ill_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            ill_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            ill_q  <= ill_d;
        end
    end

    assign out_valid       = v_q[LAST];
    assign out_regwrite    = data_q[LAST].ctrl.regwrite;
    assign out_immsrc      = data_q[LAST].ctrl.immsrc;
    assign out_alusrc      = data_q[LAST].ctrl.alusrc;
    assign out_memwrite    = data_q[LAST].ctrl.memwrite;
    assign out_resultsrc   = data_q[LAST].ctrl.resultsrc;
    assign out_branch      = data_q[LAST].ctrl.branch;
    assign out_aluop       = data_q[LAST].ctrl.aluop;
    assign out_jump        = data_q[LAST].ctrl.jump;
    assign out_pcresultsrc = data_q[LAST].ctrl.pcresultsrc;
    assign out_mdu         = data_q[LAST].mdu;
    assign out_illegal     = data_q[LAST].illegal;
    assign out_tag         = data_q[LAST].tag;
    assign ill_count       = ill_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed-vector bench for ctrl_decode_pipe (DEPTH=2, ILL_CNT_W=2 so saturation is reachable).
module tb_ctrl_decode_pipe;

    localparam int DEPTH     = 2;
    localparam int TAG_W     = 32;
    localparam int ILL_CNT_W = 2;

    localparam logic [13:0] C_LW   = 14'b1_000_1_0_001_0_00_0_0;
    localparam logic [13:0] C_SW   = 14'b0_001_1_1_000_0_00_0_0;
    localparam logic [13:0] C_R    = 14'b1_000_0_0_000_0_10_0_0;
    localparam logic [13:0] C_B    = 14'b0_010_0_0_000_1_01_0_0;
    localparam logic [13:0] C_I    = 14'b1_000_1_0_000_0_10_0_0;
    localparam logic [13:0] C_JAL  = 14'b1_011_0_0_010_0_00_1_0;
    localparam logic [13:0] C_JALR = 14'b1_000_1_0_010_0_00_1_1;
    localparam logic [13:0] C_AUI  = 14'b1_100_0_0_011_0_00_0_0;
    localparam logic [13:0] C_LUI  = 14'b1_100_0_0_100_0_00_0_0;

    logic clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic out_regwrite, out_alusrc, out_memwrite, out_branch, out_jump, out_pcresultsrc;
    logic [2:0] out_immsrc, out_resultsrc;
    logic [1:0] out_aluop;
    logic out_mdu, out_illegal;
    logic [ILL_CNT_W-1:0] ill_count;
    logic [13:0] out_ctrl;

    int vectors = 0;
    int miscompares = 0;

    ctrl_decode_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_alusrc(out_alusrc), .out_memwrite(out_memwrite),
        .out_branch(out_branch), .out_jump(out_jump), .out_pcresultsrc(out_pcresultsrc),
        .out_immsrc(out_immsrc), .out_resultsrc(out_resultsrc), .out_aluop(out_aluop),
        .out_mdu(out_mdu), .out_illegal(out_illegal), .out_tag(out_tag), .ill_count(ill_count)
    );

    assign out_ctrl = {out_regwrite, out_immsrc, out_alusrc, out_memwrite, out_resultsrc,
                       out_branch, out_aluop, out_jump, out_pcresultsrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_tag = '0;
        repeat (2) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (ill_count !== 2'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", ill_count); end
        vectors++; if (out_tag !== 32'h0) begin miscompares++; $display("FAIL reset_tag got %h want 0", out_tag); end
        vectors++; if (out_ctrl !== 14'h0) begin miscompares++; $display("FAIL reset_ctrl got %b want 0", out_ctrl); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] instr [9];
        logic [13:0] expc [9];
        instr = '{ins(7'd0, 3'b010, 7'b0000011), ins(7'd0, 3'b010, 7'b0100011),
                  ins(7'd0, 3'b000, 7'b0110011), ins(7'd0, 3'b000, 7'b1100011),
                  ins(7'd0, 3'b000, 7'b0010011), ins(7'd0, 3'b000, 7'b1101111),
                  ins(7'd0, 3'b000, 7'b1100111), ins(7'd0, 3'b000, 7'b0010111),
                  ins(7'd0, 3'b000, 7'b0110111)};
        expc = '{C_LW, C_SW, C_R, C_B, C_I, C_JAL, C_JALR, C_AUI, C_LUI};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i >= 2) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b want 1", i-2, out_valid); end
                vectors++; if (out_ctrl !== expc[i-2]) begin miscompares++; $display("FAIL b2b_ctrl[%0d] got %b want %b", i-2, out_ctrl, expc[i-2]); end
                vectors++; if (out_tag !== 32'h1000 + 32'(4*(i-2))) begin miscompares++; $display("FAIL b2b_tag[%0d] got %h", i-2, out_tag); end
                vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL b2b_ill[%0d] got %b want 0", i-2, out_illegal); end
            end
            if (i < 9) begin
                in_valid = 1'b1; in_instr = instr[i]; in_tag = 32'h1000 + 32'(4*i);
                #1;
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", out_valid); end
        vectors++; if (ill_count !== 2'd0) begin miscompares++; $display("FAIL b2b_cnt got %0d want 0", ill_count); end
    endtask

    task automatic test_illegal;
        logic [31:0] instr [2];
        instr = '{ins(7'd0, 3'b000, 7'b1111111), ins(7'd0, 3'b010, 7'b1100011)};
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ill_valid[%0d] got %b want 1", i-2, out_valid); end
                vectors++; if (out_illegal !== 1'b1) begin miscompares++; $display("FAIL ill_flag[%0d] got %b want 1", i-2, out_illegal); end
                vectors++; if (out_ctrl !== 14'h0) begin miscompares++; $display("FAIL ill_ctrl[%0d] got %b want 0", i-2, out_ctrl); end
            end
            if (i < 2) begin
                in_valid = 1'b1; in_instr = instr[i]; in_tag = 32'hA0 + 32'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        vectors++; if (ill_count !== 2'd2) begin miscompares++; $display("FAIL ill_cnt got %0d want 2", ill_count); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = ins(7'd0, 3'b000, 7'b0010011);
        in_tag = 32'hB0; #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready0 got %b want 1", in_ready); end
        @(negedge clk);
        in_tag = 32'hB1; #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        @(negedge clk);
        in_tag = 32'hB2; #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got %b want 0", in_ready); end
        vectors++; if (out_tag !== 32'hB0) begin miscompares++; $display("FAIL bp_head got %h want b0", out_tag); end
        @(negedge clk);
        vectors++; if (out_tag !== 32'hB0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold got %h/%b want b0/1", out_tag, out_valid); end
        vectors++; if (out_ctrl !== C_I) begin miscompares++; $display("FAIL bp_ctrl got %b want %b", out_ctrl, C_I); end
        out_ready = 1'b1; #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (out_tag !== 32'hB1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain1 got %h/%b want b1/1", out_tag, out_valid); end
        @(negedge clk);
        vectors++; if (out_tag !== 32'hB2 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain2 got %h/%b want b2/1", out_tag, out_valid); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = ins(7'd0, 3'b000, 7'b0010011);
        in_tag = 32'hF0;
        @(negedge clk);
        in_tag = 32'hF1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fl_pre got %b want 1", out_valid); end
        flush = 1'b1; in_instr = ins(7'd0, 3'b000, 7'b1111111); in_tag = 32'hF2; #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_ready got %b want 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_valid got %b want 0", out_valid); end
        vectors++; if (ill_count !== 2'd2) begin miscompares++; $display("FAIL fl_cnt got %0d want 2", ill_count); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_noaccept got %b want 0", out_valid); end
        vectors++; if (ill_count !== 2'd2) begin miscompares++; $display("FAIL fl_cnt2 got %0d want 2", ill_count); end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = ins(7'd0, 3'b000, 7'b0010011);
        in_tag = 32'hC0;
        @(negedge clk);
        in_tag = 32'hC1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rm_pre got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_valid got %b want 0", out_valid); end
        vectors++; if (ill_count !== 2'd0) begin miscompares++; $display("FAIL rm_cnt got %0d want 0", ill_count); end
        vectors++; if (out_tag !== 32'h0) begin miscompares++; $display("FAIL rm_tag got %h want 0", out_tag); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_post got %b/%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i >= 1) begin
                vectors++;
                if (ill_count !== ILL_CNT_W'((i > 3) ? 3 : i)) begin
                    miscompares++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, ill_count, (i > 3) ? 3 : i);
                end
            end
            if (i < 5) begin
                in_valid = 1'b1; in_instr = ins(7'd0, 3'b000, 7'b0000000); in_tag = 32'hD0 + 32'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_legality;
        logic [31:0] ti [14];
        logic [13:0] tc [14];
        logic        til [14];
        logic        tm [14];
        ti  = '{ins(7'b0100000, 3'b000, 7'b0110011), ins(7'b0100000, 3'b001, 7'b0110011),
                ins(7'b0100000, 3'b101, 7'b0110011), ins(7'b0000010, 3'b000, 7'b0110011),
                ins(7'b0000000, 3'b001, 7'b0010011), ins(7'b0100000, 3'b001, 7'b0010011),
                ins(7'b0100000, 3'b101, 7'b0010011), ins(7'b0000001, 3'b101, 7'b0010011),
                ins(7'b1111111, 3'b000, 7'b0010011), ins(7'b0000000, 3'b110, 7'b1100011),
                ins(7'b0000000, 3'b011, 7'b1100011), ins(7'b0000000, 3'b001, 7'b1100111),
                ins(7'b0000001, 3'b000, 7'b0110011), ins(7'b0000000, 3'b000, 7'b0000000)};
        tc  = '{C_R, 14'h0, C_R, 14'h0, C_I, 14'h0, C_I, 14'h0, C_I, C_B, 14'h0, 14'h0, 14'h0, 14'h0};
        til = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef CTRL_MDU_EN
        tc[12] = C_R; til[12] = 1'b0; tm[12] = 1'b1;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i >= 2) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL leg_valid[%0d] got %b want 1", i-2, out_valid); end
                vectors++; if (out_ctrl !== tc[i-2]) begin miscompares++; $display("FAIL leg_ctrl[%0d] got %b want %b", i-2, out_ctrl, tc[i-2]); end
                vectors++; if (out_illegal !== til[i-2]) begin miscompares++; $display("FAIL leg_ill[%0d] got %b want %b", i-2, out_illegal, til[i-2]); end
                vectors++; if (out_mdu !== tm[i-2]) begin miscompares++; $display("FAIL leg_mdu[%0d] got %b want %b", i-2, out_mdu, tm[i-2]); end
                vectors++; if (out_tag !== 32'h2000 + 32'(i-2)) begin miscompares++; $display("FAIL leg_tag[%0d] got %h", i-2, out_tag); end
            end
            if (i < 14) begin
                in_valid = 1'b1; in_instr = ti[i]; in_tag = 32'h2000 + 32'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_saturation();
        test_legality();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1);
    end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Pipelined, elastic control decoder for the RV32I pipeline. Accepts a 32-bit instruction plus a tag with a valid/ready handshake and decodes opcode, funct3 and funct7 into the 14-bit control bundle. The bundle travels through DEPTH register stages with per-stage backpressure and a pipeline flush. The block also flags illegal encodings and keeps a saturating count of them. It sits between fetch and the ID/EX register and replaces purely combinational decode when decode must be retimed.

## Interface
- DEPTH, 2: number of register stages (1..4); this is the latency of an unstalled instruction.
- TAG_W, 32: width of the sideband tag (normally the PC), carried unchanged.
- ILL_CNT_W, 8: width of the illegal-instruction counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage 0 can accept.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband.
- flush  in  1  kill every in-flight entry.
- out_valid  out  1  last stage holds an entry.
- out_ready  in  1  consumer accepts.
- out_regwrite, out_alusrc, out_memwrite, out_branch, out_jump, out_pcresultsrc  out  1 each.
- out_immsrc, out_resultsrc  out  3 each.
- out_aluop  out  2.
- out_mdu  out  1  multiply/divide op; constant 0 unless MDU is configured.
- out_illegal  out  1  the entry is an illegal encoding.
- out_tag  out  TAG_W.
- ill_count  out  ILL_CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode order of the bundle: {regwrite, immsrc, alusrc, memwrite, resultsrc, branch, aluop, jump, pcresultsrc}. Every don't-care bit is driven as 0.
  - 0000011 load: 1,000,1,0,001,0,00,0,0.
  - 0100011 store: 0,001,1,1,000,0,00,0,0.
  - 0110011 R-type: 1,000,0,0,000,0,10,0,0. Legal only when funct7 is 0000000, or 0100000 with funct3 000 or 101.
  - 1100011 branch: 0,010,0,0,000,1,01,0,0. funct3 010 and 011 are illegal.
  - 0010011 I-type: 1,000,1,0,000,0,10,0,0. funct3 001 requires funct7 0000000; funct3 101 requires funct7 0000000 or 0100000.
  - 1101111 jal: 1,011,0,0,010,0,00,1,0.
  - 1100111 jalr: 1,000,1,0,010,0,00,1,1. Requires funct3 000.
  - 0010111 auipc: 1,100,0,0,011,0,00,0,0.
  - 0110111 lui: 1,100,0,0,100,0,00,0,0.
  - Any other opcode, or a failed legality check, gives an all-zero bundle with illegal=1.
- Decode happens combinationally on in_instr. The result is captured into stage 0 on accept, where accept = in_valid & in_ready.
- Each stage k holds {v, bundle, mdu, illegal, tag}.
  - ready_k = !v_k | ready_(k+1); for the last stage, ready_last = !v_last | out_ready.
  - A stage loads from its predecessor when ready_k is high; bubbles collapse.
  - in_ready = ready_0 & !flush.
- Outputs come straight from the last stage's registers. The bundle is held stable while out_valid & !out_ready.
- ill_count increments by 1 on each accepted illegal instruction and saturates at all-ones. A flush does not decrement it.
- flush clears every v_k on the next edge. Nothing is accepted in a flush cycle, and ill_count does not change in that cycle.

## Timing
- Reset (rst_n low, asynchronous): all v_k = 0, all bundle, tag and illegal registers = 0, ill_count = 0, out_valid = 0, in_ready = 1 one cycle after release.
- Latency: an instruction accepted at edge t appears on out_valid after edge t+DEPTH-1, i.e. DEPTH cycles after being presented.
- Throughput: 1 instruction/cycle while out_ready is high.
- Full pipeline with out_ready low: in_ready drops combinationally in the same cycle.
- out_ready rising: in_ready rises in the same cycle, so there are no lost cycles.
- flush and out_ready high together: the last-stage entry counts as consumed in that cycle; out_valid = 0 next cycle.
- Reset asserted mid-operation: all in-flight entries are dropped immediately and the counter is zeroed.

## Configuration
- CTRL_MDU_EN defined: opcode 0110011 with funct7 0000001 (any funct3) is legal. It decodes to the R-type bundle with out_mdu = 1.
- CTRL_MDU_EN undefined: that encoding is illegal, and out_mdu is tied to 0.

## Test plan
- Reset, then feed lw, sw, add, beq, addi, jal, jalr, auipc, lui back-to-back with out_ready=1 (DEPTH=2) -> bundles exactly as listed, each arriving 2 cycles after being offered, out_valid continuous, ill_count=0.
- Opcode 1111111, then beq with funct3=010 -> both appear with illegal=1 and an all-zero bundle; ill_count=2.
- Fill the pipeline with out_ready=0 -> in_ready=0 after DEPTH accepts. Release out_ready -> entries drain in order with tags intact and no duplicates.
- Assert flush with 2 entries in flight and in_valid=1 -> the offered instruction is not accepted; out_valid=0 next cycle; ill_count unchanged.
- ILL_CNT_W=2 with 5 illegal instructions -> ill_count stops at 3. Pulse rst_n low mid-stream -> ill_count=0 and out_valid=0 immediately.
- mul encoding (funct7=0000001) -> with CTRL_MDU_EN: R-type bundle, out_mdu=1, illegal=0. Without CTRL_MDU_EN: illegal=1.
